uart_evt_word_framer: RTL and testbench
=======================================

# uart_evt_word_framer

Assembles the raw UART byte stream into 32-bit EVT2.0 words (four bytes, MSB first) and buffers them in a small FIFO with a valid/ready output toward `gradient_map_core`. It sits between `uart_rx` and the core in `gradient_map_top`, replacing the unbuffered inline assembler. It adds inter-byte-gap resynchronisation so a lost byte corrupts at most one word, and it provides saturating drop and resync counters for debug.

## Interface
- `CLK_FREQ_HZ`, 12_000_000, system clock frequency.
- `BAUD_RATE`, 115200, UART bit rate; `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE`.
- `GAP_BYTES`, 4, idle gap in byte-times that aborts a partial word; `TIMEOUT_CLKS = GAP_BYTES * 10 * CLKS_PER_BIT`.
- `FIFO_DEPTH`, 4, word FIFO depth; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte from `uart_rx`.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `evt_word`  out  32  FIFO head word; MSB = first byte received.
- `evt_word_valid`  out  1  FIFO non-empty.
- `evt_word_ready`  in  1  consumer accepts head word when high together with valid.
- `drop_count`  out  16  completed words discarded because the FIFO was full; saturates at 0xFFFF.
- `resync_count`  out  16  partial words aborted by gap timeout; saturates at 0xFFFF.
- `byte_idx`  out  2  current assembler byte position, for debug.

## Operation
- Assembler: `byte_idx` runs 0→1→2→3→0 and advances on each `rx_valid`. Bytes 0–2 load shift bits [31:24], [23:16] and [15:8]. Byte 3 forms `{shift[31:8], rx_data}` and raises a one-cycle internal `push`.
- Gap timer:
  - Cleared on every `rx_valid` and whenever `byte_idx == 0`.
  - Otherwise increments by 1 per cycle.
  - On reaching `TIMEOUT_CLKS` with no `rx_valid` in that cycle: `byte_idx ← 0`, partial bytes discarded, `resync_count` +1 (saturating), timer cleared.
  - If `rx_valid` coincides with the timeout cycle, the byte is accepted as a continuation and no resync occurs.
- FIFO: first-word-fall-through. `pop = evt_word_valid & evt_word_ready`.
  - `push` is accepted if the FIFO is not full, or if it is full and `pop` occurs in the same cycle.
  - Otherwise the word is dropped and `drop_count` +1 (saturating). The dropped word is never partially written.
- Simultaneous push and pop with the FIFO non-empty leaves occupancy unchanged. Pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked with a `log2(FIFO_DEPTH)+1`-bit counter.
- `evt_word` holds its value while `evt_word_valid` is high and `evt_word_ready` is low.
- Word content is not inspected: no EVT2 type checking. Decoding belongs to the core.

## Timing
- Reset values: `evt_word` = 0, `evt_word_valid` = 0, `drop_count` = 0, `resync_count` = 0, `byte_idx` = 0. Gap timer, pointers and occupancy are also cleared.
- Reset mid-word or with the FIFO non-empty discards all state; the first byte after reset is byte 0.
- Latency: 4th-byte `rx_valid` at cycle N → `push` registered at N+1. With the FIFO empty, `evt_word_valid` = 1 and `evt_word` is valid at N+1.
- After a pop, the next word appears on the following cycle. Valid stays high continuously while occupancy > 1.
- Throughput: one word per cycle out. Input is limited by UART at one byte per 10·`CLKS_PER_BIT` cycles.
- Timeout fires exactly `TIMEOUT_CLKS` cycles after the last accepted byte of a partial word.

## Structure
- Shared package `evt_uart_pkg`:
  - `EVT_WORD_W = 32`.
  - `BYTES_PER_WORD = 4`.
  - `typedef logic [31:0] evt_word_t`.
  - Function `uart_gap_clks(clk_hz, baud, gap_bytes)`.
- Sub-module `evt_word_fifo`: parameterised sync FWFT FIFO with push/pop, full/empty and occupancy. Assembler, gap timer and counters stay in the top of this block.
- Integration: `gradient_map_top` instantiates this block in place of its inline assembler. `evt_word`/`evt_word_valid`/`evt_word_ready` connect to the core's `evt_word`/`evt_word_valid`/`evt_word_ready`.

## Test plan
- **Basic assembly.** Stimulus: bytes 0x12, 0x34, 0x56, 0x78 with ready held high. Required: `evt_word` = 0x12345678 with valid for exactly 1 cycle, at N+1 after the 4th byte.
- **Backpressure and overflow.** Stimulus: ready low, 5 words sent, `FIFO_DEPTH` = 4. Required: `drop_count` = 1. Then, with ready high, words 1–4 emerge in order on 4 consecutive cycles; word 5 never appears.
- **Full with simultaneous pop.** Stimulus: FIFO full; ready asserted in the same cycle as a push. Required: push accepted, `drop_count` unchanged, occupancy stays 4.
- **Gap resync.** Stimulus: bytes 0xAA, 0xBB, then an idle gap of `TIMEOUT_CLKS` cycles, then 0x01, 0x02, 0x03, 0x04. Required: `resync_count` = 1 and a single word 0x01020304.
- **Gap boundary.** Stimulus: 2nd byte arrives on the exact cycle the timer reaches `TIMEOUT_CLKS`. Required: no resync; the word assembles normally.
- **Reset mid-word.** Stimulus: 2 bytes sent and 2 words queued, then `rst` for 1 cycle, then 4 fresh bytes. Required: all outputs are 0 after reset, then only the fresh word is emitted.

Source files
------------

// File: rtl/evt_uart_pkg.sv
// Shared definitions for the UART-to-EVT2.0 word path.
//   EVT_WORD_W      : width of one EVT2.0 word
//   BYTES_PER_WORD  : UART bytes per word, sent MSB first
//   evt_word_t      : 32-bit word type
//   uart_gap_clks() : converts an idle gap in UART byte-times into clock cycles
package evt_uart_pkg;

    localparam int EVT_WORD_W          = 32;
    localparam int BYTES_PER_WORD      = 4;
    // One start bit, eight data bits and one stop bit per UART byte.
    localparam int BITS_PER_UART_FRAME = 10;

    typedef logic [EVT_WORD_W-1:0] evt_word_t;

    function automatic int uart_gap_clks(input int clk_hz, input int baud, input int gap_bytes);
        return gap_bytes * BITS_PER_UART_FRAME * (clk_hz / baud);
    endfunction

endpackage

// File: rtl/evt_word_fifo.sv
// Synchronous first-word-fall-through FIFO for assembled event words.
//   clk, rst   : clock, synchronous active-high reset (pointers and occupancy)
//   push       : write push_data this cycle; ignored when full unless pop is also high
//   push_data  : word to write
//   pop        : consume the head word; ignored when empty
//   rd_data    : head word, shown combinationally; zero while empty
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module evt_word_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    occ;
    logic              wr_en;
    logic              rd_en;

    assign full  = (occ == FULL_OCC);
    assign empty = (occ == '0);
    assign count = occ;

    // When full, a write is allowed only because the same edge frees the head
    // slot; wr_ptr equals rd_ptr then, so the new word lands in that slot.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    // Forced to zero while empty so stale storage never shows on the output.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_evt_word_framer.sv
// Packs the UART byte stream into 32-bit EVT2.0 words (first byte in the MSB)
// and queues them in a small FWFT FIFO with a valid/ready output.
// A partial word is abandoned if the line stays idle for GAP_BYTES byte-times,
// so a lost byte corrupts at most one word.
//   clk, rst        : clock, synchronous active-high reset
//   rx_data/rx_valid: byte and one-cycle strobe from uart_rx
//   evt_word        : FIFO head word (zero when empty)
//   evt_word_valid  : FIFO non-empty
//   evt_word_ready  : consumer takes the head word when high with valid
//   drop_count      : words lost to a full FIFO, saturating
//   resync_count    : partial words aborted by the gap timer, saturating
//   byte_idx        : assembler byte position, for debug
module uart_evt_word_framer
    import evt_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int GAP_BYTES   = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] evt_word,
    output logic        evt_word_valid,
    input  logic        evt_word_ready,
    output logic [15:0] drop_count,
    output logic [15:0] resync_count,
    output logic [1:0]  byte_idx
);

    localparam int TIMEOUT_CLKS = uart_gap_clks(CLK_FREQ_HZ, BAUD_RATE, GAP_BYTES);
    localparam int TMR_W        = $clog2(TIMEOUT_CLKS + 1);
    // The timer is zero in the cycle after a byte, so it holds TIMEOUT_CLKS-1
    // in the cycle that lies exactly TIMEOUT_CLKS cycles after that byte.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [1:0]       LAST_IDX = 2'(BYTES_PER_WORD - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [23:0]             shift;
    logic [TMR_W-1:0]        gap_tmr;
    logic                    timeout;
    logic                    push;
    evt_word_t               push_word;
    logic                    pop;
    logic                    push_accept;
    logic                    fifo_full;
    logic                    fifo_empty;
    // Occupancy is exported by the FIFO for probing; this block does not need it.
    logic [$clog2(FIFO_DEPTH):0] fifo_level_unused;

    assign push      = rx_valid & (byte_idx == LAST_IDX);
    assign push_word = {shift, rx_data};
    // A byte arriving in the timeout cycle wins: it continues the word.
    assign timeout   = (byte_idx != 2'd0) & (gap_tmr == TMR_LAST) & ~rx_valid;

    assign evt_word_valid = ~fifo_empty;
    assign pop            = evt_word_valid & evt_word_ready;
    assign push_accept    = push & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx     <= 2'd0;
            gap_tmr      <= '0;
            drop_count   <= 16'd0;
            resync_count <= 16'd0;
        end else begin
            if (rx_valid) begin
                byte_idx <= byte_idx + 2'd1;
                gap_tmr  <= '0;
            end else if (timeout) begin
                byte_idx     <= 2'd0;
                gap_tmr      <= '0;
                resync_count <= sat_inc(resync_count);
            end else if (byte_idx == 2'd0) begin
                gap_tmr <= '0;
            end else begin
                gap_tmr <= gap_tmr + 1'b1;
            end

            if (push & ~push_accept) drop_count <= sat_inc(drop_count);
        end
    end

    // Bytes 0..2 fill the upper 24 bits; byte 3 is taken straight from rx_data.
    always_ff @(posedge clk) begin
        if (rx_valid) begin
            case (byte_idx)
                2'd0:    shift[23:16] <= rx_data;
                2'd1:    shift[15:8]  <= rx_data;
                2'd2:    shift[7:0]   <= rx_data;
                default: shift        <= shift;
            endcase
        end
    end

    evt_word_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (EVT_WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_accept),
        .push_data (push_word),
        .pop       (pop),
        .rd_data   (evt_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_level_unused)
    );

endmodule

// File: tb/tb_uart_evt_word_framer.sv
module tb_uart_evt_word_framer;

    // 1000 Hz / 100 baud = 10 clocks per bit; 1 byte-time gap = 1*10*10 = 100.
    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] evt_word;
    logic        evt_word_valid;
    logic        evt_word_ready;
    logic [15:0] drop_count;
    logic [15:0] resync_count;
    logic [1:0]  byte_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_evt_word_framer #(
        .CLK_FREQ_HZ (1000),
        .BAUD_RATE   (100),
        .GAP_BYTES   (1),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .evt_word       (evt_word),
        .evt_word_valid (evt_word_valid),
        .evt_word_ready (evt_word_ready),
        .drop_count     (drop_count),
        .resync_count   (resync_count),
        .byte_idx       (byte_idx)
    );

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    initial begin
        vecs[0] = '{b0: 8'h12, b1: 8'h34, b2: 8'h56, b3: 8'h78, exp_word: 32'h12345678};
        vecs[1] = '{b0: 8'hDE, b1: 8'hAD, b2: 8'hBE, b3: 8'hEF, exp_word: 32'hDEADBEEF};
        vecs[2] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp_word: 32'h00000000};
        vecs[3] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF, exp_word: 32'hFFFFFFFF};
        vecs[4] = '{b0: 8'h80, b1: 8'h01, b2: 8'hC3, b3: 8'h3C, exp_word: 32'h8001C33C};

        rst            = 1'b1;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        evt_word_ready = 1'b0;
        tick();
        tick();
        check("reset evt_word",     evt_word, 32'h0);
        check("reset valid",        32'(evt_word_valid), 32'h0);
        check("reset drop_count",   32'(drop_count), 32'h0);
        check("reset resync_count", 32'(resync_count), 32'h0);
        check("reset byte_idx",     32'(byte_idx), 32'h0);
        rst = 1'b0;
        tick();

        // Basic assembly, one word at a time with ready high.
        evt_word_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            send_byte(vecs[v].b0);
            check("vec byte_idx after b0", 32'(byte_idx), 32'd1);
            send_byte(vecs[v].b1);
            send_byte(vecs[v].b2);
            check("vec byte_idx after b2", 32'(byte_idx), 32'd3);
            check("vec valid before b3", 32'(evt_word_valid), 32'h0);
            send_byte(vecs[v].b3);
            check("vec valid at N+1", 32'(evt_word_valid), 32'h1);
            check("vec evt_word", evt_word, vecs[v].exp_word);
            check("vec byte_idx wrap", 32'(byte_idx), 32'd0);
            tick();
            check("vec valid one cycle", 32'(evt_word_valid), 32'h0);
        end

        // Backpressure: five words into a depth-4 FIFO.
        evt_word_ready = 1'b0;
        send_word(32'hA1A2A3A4);
        send_word(32'hB1B2B3B4);
        send_word(32'hC1C2C3C4);
        send_word(32'hD1D2D3D4);
        check("bp drop before 5th", 32'(drop_count), 32'd0);
        send_word(32'hE1E2E3E4);
        check("bp drop_count", 32'(drop_count), 32'd1);
        check("bp head held", evt_word, 32'hA1A2A3A4);
        evt_word_ready = 1'b1;
        check("bp drain w1", evt_word, 32'hA1A2A3A4);
        tick();
        check("bp drain w2", evt_word, 32'hB1B2B3B4);
        tick();
        check("bp drain w3", evt_word, 32'hC1C2C3C4);
        tick();
        check("bp drain w4", evt_word, 32'hD1D2D3D4);
        check("bp valid w4", 32'(evt_word_valid), 32'h1);
        tick();
        check("bp empty after 4", 32'(evt_word_valid), 32'h0);
        check("bp no word5", evt_word, 32'h0);

        // Full FIFO with push and pop in the same cycle.
        evt_word_ready = 1'b0;
        send_word(32'h10111213);
        send_word(32'h20212223);
        send_word(32'h30313233);
        send_word(32'h40414243);
        send_byte(8'h50);
        send_byte(8'h51);
        send_byte(8'h52);
        rx_data        = 8'h53;
        rx_valid       = 1'b1;
        evt_word_ready = 1'b1;
        tick();
        rx_valid       = 1'b0;
        evt_word_ready = 1'b0;
        check("fp drop unchanged", 32'(drop_count), 32'd1);
        check("fp new head", evt_word, 32'h20212223);
        evt_word_ready = 1'b1;
        tick();
        check("fp drain 2", evt_word, 32'h30313233);
        tick();
        check("fp drain 3", evt_word, 32'h40414243);
        tick();
        check("fp drain 4", evt_word, 32'h50515253);
        check("fp valid 4", 32'(evt_word_valid), 32'h1);
        tick();
        check("fp empty", 32'(evt_word_valid), 32'h0);

        // Gap resync: partial word abandoned after T idle cycles.
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("gap byte_idx 2", 32'(byte_idx), 32'd2);
        repeat (T - 1) tick();
        check("gap not yet", 32'(resync_count), 32'd0);
        check("gap idx held", 32'(byte_idx), 32'd2);
        tick();
        check("gap resync_count", 32'(resync_count), 32'd1);
        check("gap idx cleared", 32'(byte_idx), 32'd0);
        send_word(32'h01020304);
        check("gap word valid", 32'(evt_word_valid), 32'h1);
        check("gap word", evt_word, 32'h01020304);
        tick();
        check("gap single word", 32'(evt_word_valid), 32'h0);

        // Byte arriving exactly in the timeout cycle continues the word.
        send_byte(8'h11);
        repeat (T - 1) tick();
        check("bnd idx held", 32'(byte_idx), 32'd1);
        send_byte(8'h22);
        check("bnd idx 2", 32'(byte_idx), 32'd2);
        check("bnd no resync", 32'(resync_count), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        check("bnd word", evt_word, 32'h11223344);
        check("bnd valid", 32'(evt_word_valid), 32'h1);
        tick();

        // Reset mid-word with words queued.
        evt_word_ready = 1'b0;
        send_word(32'hCAFEBABE);
        send_word(32'h0BADF00D);
        send_byte(8'hAB);
        send_byte(8'hCD);
        check("rst pre valid", 32'(evt_word_valid), 32'h1);
        check("rst pre idx", 32'(byte_idx), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst evt_word", evt_word, 32'h0);
        check("rst valid", 32'(evt_word_valid), 32'h0);
        check("rst drop", 32'(drop_count), 32'h0);
        check("rst resync", 32'(resync_count), 32'h0);
        check("rst byte_idx", 32'(byte_idx), 32'h0);
        evt_word_ready = 1'b1;
        send_word(32'h5A6B7C8D);
        check("rst fresh word", evt_word, 32'h5A6B7C8D);
        check("rst fresh valid", 32'(evt_word_valid), 32'h1);
        tick();
        check("rst only fresh", 32'(evt_word_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
